lane_reorder_learn_rx: RTL
==========================

Name: lane_reorder_learn_rx

Overview:
Receive-side lane reorder with self-learned mapping. It sits after per-lane block sync and alignment-marker (AM) detection, and ahead of lane deskew and the descrambler. It learns which logical lane each physical lane carries from AM lane IDs, and verifies the mapping with a lock/fallback state machine. In LOCK it outputs reordered blocks, registered with one cycle of latency.

Parameters:
LANE_N, 4, number of physical/logical lanes
BLOCK_W, 66, bits per block per lane
ID_W, $clog2(LANE_N), width of one logical lane ID
MISMATCH_MAX, 3, consecutive mismatched AMs on one lane before the mapping is dropped (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
valid_i  in  1  block_i/am_i/am_id_i qualified this cycle
block_i  in  LANE_N*BLOCK_W  unordered blocks; physical lane p at [p*BLOCK_W +: BLOCK_W]
am_i  in  LANE_N  AM detected on physical lane p this cycle
am_id_i  in  LANE_N*ID_W  logical lane ID decoded from the AM on physical lane p
valid_o  out  1  block_o valid
block_o  out  LANE_N*BLOCK_W  blocks in logical order; logical lane l at [l*BLOCK_W +: BLOCK_W]
lock_o  out  1  mapping learned and valid (state==LOCK)
map_o  out  LANE_N*ID_W  learned logical ID per physical lane
err_o  out  1  single-cycle error pulse

Behaviour:
- Per-physical-lane state: seen[p] (1b), id[p] (ID_W), cnt[p] (counts to MISMATCH_MAX). map_o = concatenation of id[p].
- An AM event on lane p is valid_i & am_i[p]. AM events are ignored when valid_i=0.
- An AM event with am_id_i >= LANE_N (only possible when LANE_N is not a power of 2) is ignored and pulses err_o.
- Reset (async): state=MAP; seen, id and cnt all 0; valid_o=0, lock_o=0, err_o=0, block_o=0.
- State MAP:
  - On an AM event on lane p: id[p]<=am_id_i[p], seen[p]<=1. A re-seen lane overwrites its ID.
  - Checks run on registered values only. When all seen[] are 1: if the id[] values form a permutation of 0..LANE_N-1, the next state is LOCK. Otherwise err_o pulses, all seen[] clear, and the state stays MAP.
  - valid_o=0. block_o holds its last value.
- State LOCK:
  - Mapping is frozen; id[] is never written.
  - Data path: on valid_i, block_o[id[p]] <= block_i[p] for all p, and valid_o<=1 the next cycle. Without valid_i, valid_o<=0 and block_o holds.
  - Latency is exactly 1 clk from valid_i to valid_o.
  - On an AM event on lane p with am_id_i[p]==id[p]: cnt[p]<=0.
  - On an AM event with a mismatched ID: err_o pulses and cnt[p] increments.
  - If cnt[p] would reach MISMATCH_MAX, the next state is MAP; all seen and cnt clear; lock_o falls the next cycle. Data accepted in that fallback cycle is dropped (valid_o=0 next cycle).
  - Lanes are evaluated independently in the same cycle. Any lane reaching MISMATCH_MAX triggers fallback. err_o is OR-reduced, one pulse per cycle.
- lock_o and valid_o are registered, with no combinational path from inputs.
- The first block accepted in LOCK is the one with valid_i in the first cycle where lock_o=1.
- Reset mid-operation immediately forces the reset values, including valid_o=0.

Test Plan:
- Identity learn: LANE_N=4, AM IDs 0,1,2,3 on lanes 0..3 in one cycle -> lock_o=1 two cycles later, map_o=0xE4. Then block lane p = p+0x10 -> block_o lane l = l+0x10 with 1-cycle latency.
- Swapped map: AM IDs 2,0,3,1 arriving on separate cycles -> lock_o only after the last AM. Input lanes A,B,C,D -> output logical order B,D,A,C.
- Duplicate ID: IDs 0,0,2,3 -> err_o pulses once, seen[] cleared, lock_o stays 0. Correct AMs then follow -> lock.
- Mismatch tolerance: in LOCK, lane 1 gets a wrong ID twice then the correct one -> err_o pulses 2x, lock held, cnt reset. Three consecutive wrong IDs -> lock_o=0, valid_o=0 for the fallback-cycle data, map relearned.
- AM events with valid_i=0 have no effect. Reset asserted mid-stream in LOCK -> all outputs 0 asynchronously, state=MAP.
- Flow gaps: in LOCK, valid_i toggling 1,0,1 -> valid_o 0,1,0,1 and block_o holds during the gap.

Source files
------------

// File: rtl/lane_reorder_learn_rx_if.sv
// lane_reorder_learn_rx_if: unordered lane input and reordered lane output bundle
interface lane_reorder_learn_rx_if #(
  parameter int LANE_N = 4,
  parameter int BLOCK_W = 66,
  parameter int ID_W = $clog2(LANE_N)
);
  logic valid_i;
  logic [LANE_N*BLOCK_W-1:0] block_i;
  logic [LANE_N-1:0] am_i;
  logic [LANE_N*ID_W-1:0] am_id_i;
  logic valid_o;
  logic [LANE_N*BLOCK_W-1:0] block_o;
  logic lock_o;
  logic [LANE_N*ID_W-1:0] map_o;
  logic err_o;
  modport master(
    output valid_i, block_i, am_i, am_id_i,
    input valid_o, block_o, lock_o, map_o, err_o
  );
  modport slave(
    input valid_i, block_i, am_i, am_id_i,
    output valid_o, block_o, lock_o, map_o, err_o
  );
endinterface

// File: rtl/lane_reorder_learn_rx.sv
// lane_reorder_learn_rx: learns the physical-to-logical lane map from AM IDs and reorders blocks once locked
module lane_reorder_learn_rx #(
  parameter int LANE_N = 4,
  parameter int BLOCK_W = 66,
  parameter int ID_W = $clog2(LANE_N),
  parameter int MISMATCH_MAX = 3
) (
  input logic clk,
  input logic reset,
  lane_reorder_learn_rx_if.slave bus
);
  localparam int CNT_W = $clog2(MISMATCH_MAX + 1);
  typedef enum logic {MAP, LOCK} state_t;
  state_t state_q;
  logic [LANE_N-1:0] seen_q, ev, bad, miss, trip, hit;
  logic [ID_W-1:0] id_q [LANE_N];
  logic [CNT_W-1:0] cnt_q [LANE_N];
  logic [LANE_N*BLOCK_W-1:0] block_q, block_d;
  logic valid_q, err_q, perm, fall;
  always_comb begin
    block_d = block_q;
    hit = '0;
    for (int p = 0; p < LANE_N; p++) begin
      ev[p] = bus.valid_i & bus.am_i[p];
      bad[p] = ev[p] & ({1'b0, bus.am_id_i[p*ID_W +: ID_W]} >= (ID_W+1)'(LANE_N));
      miss[p] = ev[p] & ~bad[p] & (bus.am_id_i[p*ID_W +: ID_W] != id_q[p]);
      trip[p] = miss[p] & (32'(cnt_q[p]) + 32'd1 >= 32'(MISMATCH_MAX));
      block_d[32'(id_q[p])*BLOCK_W +: BLOCK_W] = bus.block_i[p*BLOCK_W +: BLOCK_W];
      for (int l = 0; l < LANE_N; l++) hit[l] = hit[l] | (32'(id_q[p]) == 32'(l));
    end
    perm = &hit;
    fall = (state_q == LOCK) & |trip;
  end
  // Learning updates are suspended in the cycle the complete map is judged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MAP;
      seen_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      block_q <= '0;
      for (int p = 0; p < LANE_N; p++) begin
        id_q[p] <= '0;
        cnt_q[p] <= '0;
      end
    end else begin
      err_q <= |bad;
      valid_q <= 1'b0;
      if (state_q == MAP) begin
        if (&seen_q) begin
          if (perm) state_q <= LOCK;
          else begin
            err_q <= 1'b1;
            seen_q <= '0;
          end
        end else begin
          for (int p = 0; p < LANE_N; p++)
            if (ev[p] & ~bad[p]) begin
              id_q[p] <= bus.am_id_i[p*ID_W +: ID_W];
              seen_q[p] <= 1'b1;
            end
        end
      end else if (fall) begin
        state_q <= MAP;
        seen_q <= '0;
        err_q <= 1'b1;
        for (int p = 0; p < LANE_N; p++) cnt_q[p] <= '0;
      end else begin
        err_q <= |bad | |miss;
        valid_q <= bus.valid_i;
        if (bus.valid_i) block_q <= block_d;
        for (int p = 0; p < LANE_N; p++)
          if (ev[p] & ~bad[p]) cnt_q[p] <= miss[p] ? cnt_q[p] + 1'b1 : '0;
      end
    end
  end
  for (genvar g = 0; g < LANE_N; g++) begin : g_map
    assign bus.map_o[g*ID_W +: ID_W] = id_q[g];
  end
  assign bus.valid_o = valid_q;
  assign bus.block_o = block_q;
  assign bus.lock_o = state_q == LOCK;
  assign bus.err_o = err_q;
endmodule
